instr_prefetch_unit: RTL



---
 rtl/instr_prefetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch front end: owns the fetch PC, issues word reads
// over req/ack, buffers {pc, instr} pairs in a FIFO popped by decode.
// Ports: clk, rst (async, active-high); redirect/redirect_pc restart fetch;
// mem_req/mem_addr/mem_ack/mem_rdata memory side; instr_valid/instr/
// instr_pc/instr_ready decode side; fifo_count = occupied entries.
module instr_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  output logic                       instr_valid,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DISCARD
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_n;
  logic [31:0]   addr_q;
  logic [31:0]   addr_n;
  logic [31:0]   tgt;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          space;

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];

  assign tgt     = redirect_pc & ~32'h3;
  // Redirect wins over both push and pop; the FIFO is flushed instead.
  assign push    = (state == BUSY) && mem_ack && !redirect;
  assign pop     = (count != '0) && instr_ready && !redirect;
  assign cnt_nxt = count + CW'(push) - CW'(pop);
  // Only issue when the returning word is guaranteed a slot.
  assign space   = cnt_nxt < CW'(DEPTH);

  always_comb begin
    state_n = state;
    fetch_n = fetch_pc;
    addr_n  = addr_q;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          fetch_n = tgt;
        end else if (space) begin
          state_n = BUSY;
          addr_n  = fetch_pc;
          fetch_n = fetch_pc + 32'd4;
        end
      end
      BUSY: begin
        if (redirect) begin
          fetch_n = tgt;
          state_n = mem_ack ? IDLE : DISCARD;
        end else if (mem_ack) begin
          if (space) begin
            addr_n  = fetch_pc;
            fetch_n = fetch_pc + 32'd4;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DISCARD: begin
        // Wait out the abandoned request; its data is dropped.
        if (mem_ack) begin
          state_n = BUSY;
          addr_n  = redirect ? tgt : fetch_pc;
          fetch_n = addr_n + 32'd4;
        end else if (redirect) begin
          fetch_n = tgt;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_n;
      addr_q   <= addr_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]  <= addr_q;
      ins_mem[wr_ptr] <= mem_rdata;
    end
  end

  assign mem_req     = (state != IDLE);
  assign mem_addr    = addr_q;
  assign instr_valid = (count != '0);
  assign instr       = ins_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign fifo_count  = count;

endmodule
